// File: rtl/bist_mem_datapath.sv
// Memory-side datapath for a march-test BIST: address up/down counter, memory under test,
// read-compare with optional read-path stuck-at injection, and first-failure capture.
module bist_mem_datapath #(
    parameter  int AW    = 4,
    parameter  int WIDTH = 8,
    localparam int DEPTH = 1 << AW,
    localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic             up_down,
    input  logic             read,
    input  logic             write,
    input  logic             data,
    output logic             carry,
    output logic             is_equal,
    output logic [AW-1:0]    addr,
    output logic             err_valid,
    output logic [AW-1:0]    err_addr,
    output logic [WIDTH-1:0] err_data,
    output logic [7:0]       err_count,
    input  logic             inj_en,
    input  logic [AW-1:0]    inj_addr,
    input  logic [BW-1:0]    inj_bit,
    input  logic             inj_val
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    addr_q, addr_d;
    logic             is_equal_q;
    logic             err_valid_q;
    logic [AW-1:0]    err_addr_q;
    logic [WIDTH-1:0] err_data_q;
    logic [7:0]       err_count_q;

    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] rd_word;
    logic             mismatch;

    assign exp_word = {WIDTH{data}};

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_word = mem[addr_q];
        if (inj_en && (addr_q == inj_addr)) begin
            rd_word[inj_bit] = inj_val;
        end
    end

    assign mismatch = read && (rd_word != exp_word);

    always_comb begin
        addr_d = addr_q;
        if (reset) begin
            addr_d = '0;
        end else if (preset) begin
            addr_d = AW'(DEPTH - 1);
        end else if (en) begin
            addr_d = up_down ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

    // NOTE: the memory array has no reset; only the write strobe is held off while rst_n is low.
    always_ff @(posedge clk) begin
        if (write && rst_n) begin
            mem[addr_q] <= exp_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so reads on this edge see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            is_equal_q  <= 1'b1;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            err_count_q <= '0;
        end else begin
            addr_q <= addr_d;

            if (read) begin
                is_equal_q <= !mismatch;
            end else if (reset) begin
                is_equal_q <= 1'b1;
            end

            // A clear command wins over a mismatch seen on the same edge.
            if (reset) begin
                err_valid_q <= 1'b0;
                err_addr_q  <= '0;
                err_data_q  <= '0;
                err_count_q <= '0;
            end else if (mismatch) begin
                if (err_count_q != 8'hFF) begin
                    err_count_q <= err_count_q + 8'd1;
                end
                if (!err_valid_q) begin
                    err_valid_q <= 1'b1;
                    err_addr_q  <= addr_q;
                    err_data_q  <= rd_word;
                end
            end
        end
    end

    assign carry     = up_down ? (addr_q == AW'(DEPTH - 1)) : (addr_q == '0);
    assign addr      = addr_q;
    assign is_equal  = is_equal_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_bist_mem_datapath.sv
// Directed bench for bist_mem_datapath: counter walk, march fill/verify, fault injection,
// error capture, read-first collision, saturation and asynchronous reset.
module tb_bist_mem_datapath;

    localparam int AW    = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             reset, preset, en, up_down, read, write, data;
    logic             carry, is_equal, err_valid;
    logic [AW-1:0]    addr, err_addr;
    logic [WIDTH-1:0] err_data;
    logic [7:0]       err_count;
    logic             inj_en, inj_val;
    logic [AW-1:0]    inj_addr;
    logic [2:0]       inj_bit;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bist_mem_datapath #(.AW(AW), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reset     (reset),
        .preset    (preset),
        .en        (en),
        .up_down   (up_down),
        .read      (read),
        .write     (write),
        .data      (data),
        .carry     (carry),
        .is_equal  (is_equal),
        .addr      (addr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
        .err_data  (err_data),
        .err_count (err_count),
        .inj_en    (inj_en),
        .inj_addr  (inj_addr),
        .inj_bit   (inj_bit),
        .inj_val   (inj_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; reset = 0; preset = 0; en = 0; up_down = 0;
        read = 0; write = 0; data = 0;
        inj_en = 0; inj_addr = '0; inj_bit = '0; inj_val = 0;

        // Power-on reset state
        #12;
        check("rst_addr", 32'(addr), 0);
        check("rst_is_equal", 32'(is_equal), 1);
        check("rst_err_valid", 32'(err_valid), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_carry_down", 32'(carry), 1);
        up_down = 1; #1;
        check("rst_carry_up", 32'(carry), 0);
        #4 rst_n = 1'b1;

        // Up-count walk through every address and wrap
        reset = 1; step(); reset = 0;
        check("walk_start", 32'(addr), 0);
        en = 1; up_down = 1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("walk_addr", 32'(addr), 32'(i));
            check("walk_carry", 32'(carry), (i == 15) ? 1 : 0);
        end
        step();
        check("wrap_addr", 32'(addr), 0);
        check("wrap_carry", 32'(carry), 0);
        en = 0;

        // Descending fill with all-ones
        preset = 1; step(); preset = 0;
        check("preset_addr", 32'(addr), 15);
        up_down = 0; write = 1; en = 1; data = 1;
        for (int i = 0; i < 16; i++) step();
        write = 0; en = 0;
        check("fill_end_addr", 32'(addr), 15);

        // Ascending verify: every word must compare equal
        reset = 1; step(); reset = 0;
        read = 1; en = 1; up_down = 1; data = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            check("verify_eq", 32'(is_equal), 1);
        end
        check("verify_err_count", 32'(err_count), 0);
        check("verify_err_valid", 32'(err_valid), 0);

        // Same pass with stuck-at-0 on bit 3 of address 5
        inj_en = 1; inj_addr = 4'd5; inj_bit = 3'd3; inj_val = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("inj_eq", 32'(is_equal), (i == 5) ? 0 : 1);
            if (i == 5) begin
                check("inj_err_valid", 32'(err_valid), 1);
                check("inj_err_addr", 32'(err_addr), 5);
                check("inj_err_data", 32'(err_data), 32'hF7);
                check("inj_err_count", 32'(err_count), 1);
            end
        end
        read = 0; inj_en = 0;
        check("inj_final_count", 32'(err_count), 1);

        // Stored data at address 5 is intact, then overwrite with zeros
        for (int i = 0; i < 5; i++) step();
        en = 0;
        check("nav5_addr", 32'(addr), 5);
        read = 1; data = 1; step();
        check("intact_eq", 32'(is_equal), 1);
        read = 0; write = 1; data = 0; step();
        write = 0; read = 1; data = 0; step();
        check("zero_eq", 32'(is_equal), 1);
        read = 0;
        check("intact_count", 32'(err_count), 1);

        // Two mismatches: capture keeps the first
        reset = 1; step(); reset = 0;
        check("clr_err_valid", 32'(err_valid), 0);
        en = 1; step(); step(); en = 0;
        inj_en = 1; inj_addr = 4'd2; inj_bit = 3'd0; inj_val = 0;
        read = 1; data = 1; step();
        check("m1_eq", 32'(is_equal), 0);
        check("m1_err_addr", 32'(err_addr), 2);
        check("m1_count", 32'(err_count), 1);
        read = 0; en = 1;
        for (int i = 0; i < 7; i++) step();
        en = 0;
        check("nav9_addr", 32'(addr), 9);
        inj_addr = 4'd9; read = 1; step();
        check("m2_eq", 32'(is_equal), 0);
        check("m2_count", 32'(err_count), 2);
        check("m2_err_addr", 32'(err_addr), 2);
        check("m2_err_data", 32'(err_data), 32'hFE);
        read = 0; inj_en = 0;
        reset = 1; step(); reset = 0;
        check("pulse_err_valid", 32'(err_valid), 0);
        check("pulse_count", 32'(err_count), 0);
        check("pulse_is_equal", 32'(is_equal), 1);
        check("pulse_addr", 32'(addr), 0);

        // Read-first collision at address 3
        en = 1; step(); step(); step(); en = 0;
        write = 1; data = 0; step();
        read = 1; write = 1; data = 1; step();
        check("rw_eq_old", 32'(is_equal), 0);
        check("rw_err_addr", 32'(err_addr), 3);
        check("rw_err_data", 32'(err_data), 32'h00);
        write = 0; step();
        check("rw_eq_new", 32'(is_equal), 1);
        check("rw_addr_held", 32'(addr), 3);

        // Error counter saturates at 255 while capture is frozen
        data = 0;
        for (int i = 0; i < 256; i++) step();
        read = 0;
        check("sat_count", 32'(err_count), 255);
        check("sat_err_addr", 32'(err_addr), 3);
        check("sat_err_data", 32'(err_data), 32'h00);

        // reset outranks preset
        reset = 1; preset = 1; step(); reset = 0;
        check("prio_reset", 32'(addr), 0);
        step(); preset = 0;
        check("prio_preset", 32'(addr), 15);
        up_down = 0; #1;
        check("carry_down_15", 32'(carry), 0);
        up_down = 1; #1;
        check("carry_up_15", 32'(carry), 1);

        // Asynchronous reset mid-count
        en = 1; step(); step(); en = 0;
        check("pre_async_addr", 32'(addr), 1);
        #3 rst_n = 1'b0; #1;
        check("async_addr", 32'(addr), 0);
        check("async_is_equal", 32'(is_equal), 1);
        check("async_err_count", 32'(err_count), 0);
        check("async_err_valid", 32'(err_valid), 0);
        #3 rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
